true_dpram_sclk_be: RTL and testbench
=====================================

// Module: true_dpram_sclk_be
// PURPOSE
//  Single-clock true dual-port RAM. Each port independently reads or writes any address every cycle.
//  Adds byte-lane write enables, a selectable read-during-write mode and 1- or 2-cycle read latency.
//  Detects and arbitrates same-address collisions, and clears the array to zero after reset.
//  Serves same-clock-domain shared buffers. Cross-domain buffers use the dual-clock RAM.
// PARAMETERS
//  WIDTH          16  data width in bits; must be a multiple of BYTE_W
//  ADDRESS         6  address width in bits; DEPTH = 2**ADDRESS words
//  BYTE_W          8  bits per byte lane; NB = WIDTH/BYTE_W lanes
//  RDW_MODE        0  read-during-write: 0 = read-first (old data), 1 = write-first (new data)
//  READ_LATENCY    1  cycles from access edge to data_out/valid; 1 or 2 only
//  CLEAR_ON_RESET  1  1 = zero the whole array after reset; 0 = contents undefined after reset
// PORTS
//  clk         in   1        single clock; all logic on rising edge
//  rst_n       in   1        asynchronous active-low reset
//  en_A        in   1        port A access request
//  wr_en_A     in   1        port A write (qualified by en_A)
//  be_A        in   NB       port A byte-lane write enables
//  addr_A      in   ADDRESS  port A address
//  data_in_A   in   WIDTH    port A write data
//  data_out_A  out  WIDTH    port A read data
//  valid_A     out  1        port A read data valid, 1-cycle pulse per accepted access
//  en_B, wr_en_B, be_B, addr_B, data_in_B, data_out_B, valid_B: same as port A, for port B
//  collision   out  1        1-cycle pulse: same-address access with at least one writer
//  init_busy   out  1        high while the clear sequence runs; accesses are ignored
// BEHAVIOUR
//  Reset (rst_n low, asynchronous): data_out_* = 0, valid_* = 0, collision = 0.
//   Pipeline registers = 0. init_busy = CLEAR_ON_RESET. Memory array is not reset directly.
//  FSM states: CLEAR and READY.
//   On reset: CLEAR if CLEAR_ON_RESET, else READY.
//   CLEAR: writes 0 to address cnt each cycle, cnt runs 0..DEPTH-1.
//   After cnt = DEPTH-1: go to READY and drop init_busy.
//   init_busy is high for exactly DEPTH cycles after rst_n rises.
//   Reset asserted mid-CLEAR: cnt returns to 0 and the sequence restarts in full.
//  Access is accepted at an edge when en_X = 1 and init_busy = 0.
//   Accesses during CLEAR are dropped: no write, no valid pulse.
//  Write (wr_en_X = 1): only lanes with be_X[i] = 1 are updated.
//   be_X = 0 with wr_en_X = 1 writes nothing but still returns read data.
//  Every accepted access (read or write) returns a read of addr_X.
//   Data and valid_X appear READY_LATENCY edges later: READ_LATENCY edges after the access edge.
//   With READ_LATENCY = 2, one extra output register stage is inserted.
//   data_out_X holds its last value when valid_X = 0.
//  RDW on the same port, and on the other port at the same address:
//   RDW_MODE 0: returns pre-write contents.
//   RDW_MODE 1: returns the final post-write contents, including the A/B lane merge.
//  Write-write collision at the same address, per lane:
//   lane enabled by A: A data wins; lane enabled only by B: B data.
//   lane enabled by neither: unchanged.
//  collision: registered; pulses in the cycle after the access edge (independent of READ_LATENCY).
//   Two reads of the same address: no collision, both ports return data.
//  Different addresses: ports fully independent, no interaction.
//  Address wrap: none. Every ADDRESS-bit value is valid.
//  READ_LATENCY outside {1,2} or WIDTH % BYTE_W != 0: elaboration error.
// TESTING (defaults WIDTH=16, ADDRESS=6, BYTE_W=8; clk period 10)
//  1 Release rst_n -> init_busy high exactly 64 cycles.
//    Then read A@3F -> valid_A 1 cycle later, data_out_A = 0000.
//  2 Write A@28 = B5C3 be=11 and B@3D = 6F12 be=11 together.
//    Then read B@28, A@3D -> data_out_B = B5C3, data_out_A = 6F12.
//  3 Write A@28 = FFAA be=01, then read A@28 -> B5AA.
//    Write with be=00 -> unchanged B5AA.
//  4 Same edge: A@10 = 1111 be=10, B@10 = 2222 be=11.
//    -> collision pulse 1 cycle; read @10 -> 1122.
//  5 A writes @28 = 1234 while B reads @28.
//    -> B gets B5AA (RDW_MODE 0) or 1234 (RDW_MODE 1); collision pulses.
//    Repeat with READ_LATENCY=2 -> valid two edges after access.
//  6 Assert rst_n low at CLEAR cycle 20 -> outputs 0 immediately, init_busy stays high.
//    After release: 64 more busy cycles; en_A during busy -> no valid_A.

Source files
------------

// File: rtl/true_dpram_sclk_be.sv
// Single-clock true dual-port RAM with byte-lane write enables,
// selectable read-during-write behaviour, 1- or 2-cycle read latency,
// same-address collision arbitration and a zero-fill sequence after reset.
module true_dpram_sclk_be #(
    parameter int WIDTH          = 16,
    parameter int ADDRESS        = 6,
    parameter int BYTE_W         = 8,
    parameter int RDW_MODE       = 0,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NB            = WIDTH / BYTE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_A,
    input  logic               wr_en_A,
    input  logic [NB-1:0]      be_A,
    input  logic [ADDRESS-1:0] addr_A,
    input  logic [WIDTH-1:0]   data_in_A,
    output logic [WIDTH-1:0]   data_out_A,
    output logic               valid_A,
    input  logic               en_B,
    input  logic               wr_en_B,
    input  logic [NB-1:0]      be_B,
    input  logic [ADDRESS-1:0] addr_B,
    input  logic [WIDTH-1:0]   data_in_B,
    output logic [WIDTH-1:0]   data_out_B,
    output logic               valid_B,
    output logic               collision,
    output logic               init_busy
);

    localparam int DEPTH = 2 ** ADDRESS;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 2 || (WIDTH % BYTE_W) != 0) begin : g_bad_params
            $error("true_dpram_sclk_be: READ_LATENCY must be 1 or 2 and WIDTH a multiple of BYTE_W");
        end
    endgenerate

    typedef enum logic {CLEAR, READY} state_t;

    state_t             state, state_nxt;
    logic [ADDRESS-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic               same;
    logic [1:0]         acc;
    logic               wr_a, wr_b;
    logic [WIDTH-1:0]   old_a, old_b, new_a, new_b;
    logic [1:0][WIDTH-1:0] rd;

    // read-data pipeline; stage READ_LATENCY drives the outputs
    logic [READ_LATENCY:1][1:0]            vld_pipe;
    logic [READ_LATENCY:1][1:0][WIDTH-1:0] dat_pipe;

    assign init_busy = (state == CLEAR);
    assign acc       = {en_B & ~init_busy, en_A & ~init_busy};
    assign wr_a      = acc[0] & wr_en_A;
    assign wr_b      = acc[1] & wr_en_B;
    assign same      = (addr_A == addr_B);
    assign old_a     = mem[addr_A];
    assign old_b     = mem[addr_B];

    // Per-lane merge: A wins a lane it enables, B fills lanes only it enables.
    // At a shared address both ports see the identical merged word.
    generate
        for (genvar i = 0; i < NB; i++) begin : g_lane
            assign new_a[i*BYTE_W +: BYTE_W] =
                (wr_a & be_A[i])        ? data_in_A[i*BYTE_W +: BYTE_W] :
                (wr_b & same & be_B[i]) ? data_in_B[i*BYTE_W +: BYTE_W] :
                                          old_a[i*BYTE_W +: BYTE_W];
            assign new_b[i*BYTE_W +: BYTE_W] =
                (wr_a & same & be_A[i]) ? data_in_A[i*BYTE_W +: BYTE_W] :
                (wr_b & be_B[i])        ? data_in_B[i*BYTE_W +: BYTE_W] :
                                          old_b[i*BYTE_W +: BYTE_W];
        end
    endgenerate

    assign rd[0] = (RDW_MODE != 0) ? new_a : old_a;
    assign rd[1] = (RDW_MODE != 0) ? new_b : old_b;

    // Init FSM state and clear-address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Walk every address once, then hand the array to the ports
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == CLEAR) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == '1) state_nxt = READY;
        end
    end

    // Array write: clear sequence, else merged words from either port
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[cnt] <= '0;
        end else begin
            if (wr_a || (wr_b && same)) mem[addr_A] <= new_a;
            if (wr_b || (wr_a && same)) mem[addr_B] <= new_b;
        end
    end

    // Read pipeline and collision flag; data registers only load on valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            dat_pipe  <= '0;
            collision <= 1'b0;
        end else begin
            vld_pipe[1] <= acc;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) dat_pipe[1][p] <= rd[p];
            end
            for (int s = 2; s <= READ_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                for (int p = 0; p < 2; p++) begin
                    if (vld_pipe[s-1][p]) dat_pipe[s][p] <= dat_pipe[s-1][p];
                end
            end
            collision <= acc[0] & acc[1] & same & (wr_en_A | wr_en_B);
        end
    end

    assign valid_A    = vld_pipe[READ_LATENCY][0];
    assign valid_B    = vld_pipe[READ_LATENCY][1];
    assign data_out_A = dat_pipe[READ_LATENCY][0];
    assign data_out_B = dat_pipe[READ_LATENCY][1];

endmodule

// File: tb/tb_true_dpram_sclk_be.sv
// Directed bench: default instance (read-first, latency 1) plus a
// write-first, latency-2 instance sharing the same stimulus.
module tb_true_dpram_sclk_be;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_A = 1'b0, wr_en_A = 1'b0, en_B = 1'b0, wr_en_B = 1'b0;
    logic [1:0]  be_A = '0, be_B = '0;
    logic [5:0]  addr_A = '0, addr_B = '0;
    logic [15:0] data_in_A = '0, data_in_B = '0;

    logic [15:0] data_out_A, data_out_B, data_out_A2, data_out_B2;
    logic        valid_A, valid_B, collision, init_busy;
    logic        valid_A2, valid_B2, collision2, init_busy2;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    true_dpram_sclk_be dut (
        .clk(clk), .rst_n(rst_n),
        .en_A(en_A), .wr_en_A(wr_en_A), .be_A(be_A), .addr_A(addr_A), .data_in_A(data_in_A),
        .data_out_A(data_out_A), .valid_A(valid_A),
        .en_B(en_B), .wr_en_B(wr_en_B), .be_B(be_B), .addr_B(addr_B), .data_in_B(data_in_B),
        .data_out_B(data_out_B), .valid_B(valid_B),
        .collision(collision), .init_busy(init_busy)
    );

    true_dpram_sclk_be #(.RDW_MODE(1), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .en_A(en_A), .wr_en_A(wr_en_A), .be_A(be_A), .addr_A(addr_A), .data_in_A(data_in_A),
        .data_out_A(data_out_A2), .valid_A(valid_A2),
        .en_B(en_B), .wr_en_B(wr_en_B), .be_B(be_B), .addr_B(addr_B), .data_in_B(data_in_B),
        .data_out_B(data_out_B2), .valid_B(valid_B2),
        .collision(collision2), .init_busy(init_busy2)
    );

    typedef struct {
        logic en_a; logic we_a; logic [1:0] be_a; logic [5:0] ad_a; logic [15:0] di_a;
        logic en_b; logic we_b; logic [1:0] be_b; logic [5:0] ad_b; logic [15:0] di_b;
        logic va; logic [15:0] da; logic vb; logic [15:0] db; logic coll;
        logic va2; logic [15:0] da2; logic vb2; logic [15:0] db2;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        en_A = 1'b0; wr_en_A = 1'b0; be_A = '0;
        en_B = 1'b0; wr_en_B = 1'b0; be_B = '0;
    endtask

    // Count edges while the default instance reports busy (bounded)
    task automatic count_busy(output int n, output logic sawv);
        n = 0;
        sawv = 1'b0;
        while (init_busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (valid_A === 1'b1 || valid_B === 1'b1 || valid_A2 === 1'b1) sawv = 1'b1;
        end
    endtask

    initial begin
        int   n;
        logic sawv;

        //          en we be     addr    din        en we be     addr    din        va   da          vb   db          c     va2  da2         vb2  db2
        tbl[0]  = '{1'b1,1'b0,2'b00,6'h3F,16'h0000, 1'b0,1'b0,2'b00,6'h00,16'h0000, 1'b1,16'h0000,1'b0,16'h0000,1'b0, 1'b0,16'h0000,1'b0,16'h0000};
        tbl[1]  = '{1'b1,1'b1,2'b11,6'h28,16'hB5C3, 1'b1,1'b1,2'b11,6'h3D,16'h6F12, 1'b1,16'h0000,1'b1,16'h0000,1'b0, 1'b1,16'h0000,1'b0,16'h0000};
        tbl[2]  = '{1'b1,1'b0,2'b00,6'h3D,16'h0000, 1'b1,1'b0,2'b00,6'h28,16'h0000, 1'b1,16'h6F12,1'b1,16'hB5C3,1'b0, 1'b1,16'hB5C3,1'b1,16'h6F12};
        tbl[3]  = '{1'b1,1'b1,2'b01,6'h28,16'hFFAA, 1'b0,1'b0,2'b00,6'h00,16'h0000, 1'b1,16'hB5C3,1'b0,16'hB5C3,1'b0, 1'b1,16'h6F12,1'b1,16'hB5C3};
        tbl[4]  = '{1'b1,1'b0,2'b00,6'h28,16'h0000, 1'b0,1'b0,2'b00,6'h00,16'h0000, 1'b1,16'hB5AA,1'b0,16'hB5C3,1'b0, 1'b1,16'hB5AA,1'b0,16'hB5C3};
        tbl[5]  = '{1'b1,1'b1,2'b00,6'h28,16'h0000, 1'b0,1'b0,2'b00,6'h00,16'h0000, 1'b1,16'hB5AA,1'b0,16'hB5C3,1'b0, 1'b1,16'hB5AA,1'b0,16'hB5C3};
        tbl[6]  = '{1'b1,1'b0,2'b00,6'h28,16'h0000, 1'b0,1'b0,2'b00,6'h00,16'h0000, 1'b1,16'hB5AA,1'b0,16'hB5C3,1'b0, 1'b1,16'hB5AA,1'b0,16'hB5C3};
        tbl[7]  = '{1'b1,1'b1,2'b10,6'h10,16'h1111, 1'b1,1'b1,2'b11,6'h10,16'h2222, 1'b1,16'h0000,1'b1,16'h0000,1'b1, 1'b1,16'hB5AA,1'b0,16'hB5C3};
        tbl[8]  = '{1'b1,1'b0,2'b00,6'h10,16'h0000, 1'b1,1'b0,2'b00,6'h10,16'h0000, 1'b1,16'h1122,1'b1,16'h1122,1'b0, 1'b1,16'h1122,1'b1,16'h1122};
        tbl[9]  = '{1'b1,1'b1,2'b11,6'h28,16'h1234, 1'b1,1'b0,2'b00,6'h28,16'h0000, 1'b1,16'hB5AA,1'b1,16'hB5AA,1'b1, 1'b1,16'h1122,1'b1,16'h1122};
        tbl[10] = '{1'b0,1'b0,2'b00,6'h00,16'h0000, 1'b0,1'b0,2'b00,6'h00,16'h0000, 1'b0,16'hB5AA,1'b0,16'hB5AA,1'b0, 1'b1,16'h1234,1'b1,16'h1234};
        tbl[11] = '{1'b0,1'b0,2'b00,6'h00,16'h0000, 1'b1,1'b0,2'b00,6'h28,16'h0000, 1'b0,16'hB5AA,1'b1,16'h1234,1'b0, 1'b0,16'h1234,1'b0,16'h1234};
        tbl[12] = '{1'b1,1'b1,2'b11,6'h3F,16'hABCD, 1'b1,1'b1,2'b01,6'h00,16'h5A5A, 1'b1,16'h0000,1'b1,16'h0000,1'b0, 1'b0,16'h1234,1'b1,16'h1234};
        tbl[13] = '{1'b1,1'b0,2'b00,6'h00,16'h0000, 1'b1,1'b0,2'b00,6'h3F,16'h0000, 1'b1,16'h005A,1'b1,16'hABCD,1'b0, 1'b1,16'hABCD,1'b1,16'h005A};

        // Reset state
        #12;
        chk("rst data_out_A", data_out_A, 16'h0);
        chk("rst data_out_B", data_out_B, 16'h0);
        chk("rst valid_A", {15'b0, valid_A}, 16'h0);
        chk("rst valid_B", {15'b0, valid_B}, 16'h0);
        chk("rst collision", {15'b0, collision}, 16'h0);
        chk("rst init_busy", {15'b0, init_busy}, 16'h1);

        // Clear sequence length
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_busy(n, sawv);
        chk("busy cycles", n[15:0], 16'd64);
        chk("busy2 low", {15'b0, init_busy2}, 16'h0);

        // Vector table, one access edge per row
        for (int i = 0; i < 14; i++) begin
            en_A = tbl[i].en_a; wr_en_A = tbl[i].we_a; be_A = tbl[i].be_a;
            addr_A = tbl[i].ad_a; data_in_A = tbl[i].di_a;
            en_B = tbl[i].en_b; wr_en_B = tbl[i].we_b; be_B = tbl[i].be_b;
            addr_B = tbl[i].ad_b; data_in_B = tbl[i].di_b;
            @(posedge clk); #1;
            chk($sformatf("v%0d valid_A", i), {15'b0, valid_A}, {15'b0, tbl[i].va});
            chk($sformatf("v%0d data_out_A", i), data_out_A, tbl[i].da);
            chk($sformatf("v%0d valid_B", i), {15'b0, valid_B}, {15'b0, tbl[i].vb});
            chk($sformatf("v%0d data_out_B", i), data_out_B, tbl[i].db);
            chk($sformatf("v%0d collision", i), {15'b0, collision}, {15'b0, tbl[i].coll});
            chk($sformatf("v%0d wf valid_A", i), {15'b0, valid_A2}, {15'b0, tbl[i].va2});
            chk($sformatf("v%0d wf data_out_A", i), data_out_A2, tbl[i].da2);
            chk($sformatf("v%0d wf valid_B", i), {15'b0, valid_B2}, {15'b0, tbl[i].vb2});
            chk($sformatf("v%0d wf data_out_B", i), data_out_B2, tbl[i].db2);
            chk($sformatf("v%0d wf collision", i), {15'b0, collision2}, {15'b0, tbl[i].coll});
        end

        // Drain the latency-2 pipeline for the last row
        idle();
        @(posedge clk); #1;
        chk("drain valid_A", {15'b0, valid_A}, 16'h0);
        chk("drain data_out_A hold", data_out_A, 16'h005A);
        chk("drain wf valid_A", {15'b0, valid_A2}, 16'h1);
        chk("drain wf data_out_A", data_out_A2, 16'h005A);
        chk("drain wf data_out_B", data_out_B2, 16'hABCD);

        // Async reset clears outputs immediately, mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("async data_out_A", data_out_A, 16'h0);
        chk("async data_out_B", data_out_B, 16'h0);
        chk("async wf data_out_A", data_out_A2, 16'h0);
        chk("async init_busy", {15'b0, init_busy}, 16'h1);

        // Re-assert reset at clear cycle 20: sequence restarts in full
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("mid-clear busy", {15'b0, init_busy}, 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-clear rst busy", {15'b0, init_busy}, 16'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        en_A = 1'b1; wr_en_A = 1'b0; addr_A = 6'h28;
        count_busy(n, sawv);
        chk("restart busy cycles", n[15:0], 16'd64);
        chk("no valid while busy", {15'b0, sawv}, 16'h0);

        // First accepted read after clear: former 1234 now zero
        @(posedge clk); #1;
        idle();
        chk("post-clear valid_A", {15'b0, valid_A}, 16'h1);
        chk("post-clear data_out_A", data_out_A, 16'h0000);
        chk("post-clear wf valid_A early", {15'b0, valid_A2}, 16'h0);
        @(posedge clk); #1;
        chk("post-clear wf valid_A", {15'b0, valid_A2}, 16'h1);
        chk("post-clear wf data_out_A", data_out_A2, 16'h0000);
        chk("post-clear valid_A drop", {15'b0, valid_A}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want done");
        $fatal(1, "timeout");
    end

endmodule
